// File: rtl/ldm_burst_master_if.sv
// Command, write-stream and read-stream bundle of the LDM burst engine.
// master = host/DMA side driving commands, slave = the burst engine.
interface ldm_burst_master_if #(
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_dir;
   logic [AWIDTH-1:0] cmd_addr;
   logic [AWIDTH:0]   cmd_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [DWIDTH-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DWIDTH-1:0] rd_data;

   modport master (
      output cmd_valid, cmd_dir, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
      input  cmd_ready, wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
      output cmd_ready, wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/ldm_burst_master.sv
// Burst engine for one LDM port: streams a contiguous word block into or out of the LDM.
// Optional: define LDM_BURST_RANGE_CHK_EN to reject bursts that run past the top address.
module ldm_burst_master #(
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   ldm_burst_master_if.slave bus,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_din,
   input  logic [DWIDTH-1:0] mem_dout,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t            state_r;
   logic [AWIDTH-1:0] addr_r;
   logic [AWIDTH:0]   remaining_r;
   logic              inflight_r;
   logic              done_r;
   logic [DWIDTH-1:0] fifo_mem_r [3];
   logic [1:0]        fifo_rd_ptr_r;
   logic [1:0]        fifo_wr_ptr_r;
   logic [1:0]        fifo_count_r;
   logic              wr_beat_s;
   logic              rd_issue_s;
   logic              fifo_push_s;
   logic              fifo_pop_s;
   logic              last_word_s;
   logic              rd_valid_s;
   logic              reject_s;

   function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
      return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
   endfunction

   // Beat/issue qualification; fetch-ahead is capped at 3 words counting the read in flight.
   always_comb begin
      wr_beat_s   = 1'b0;
      rd_issue_s  = 1'b0;
      last_word_s = (remaining_r == (AWIDTH+1)'(1));
      if (state_r == ST_WRITE) begin
         wr_beat_s = bus.wr_valid;
      end else if (state_r == ST_READ) begin
         rd_issue_s = (remaining_r != '0) &&
                      (({1'b0, fifo_count_r} + {2'b00, inflight_r}) < 3'd3);
      end else begin
         wr_beat_s  = 1'b0;
         rd_issue_s = 1'b0;
      end
      rd_valid_s  = (fifo_count_r != 2'd0);
      fifo_push_s = inflight_r;
      fifo_pop_s  = rd_valid_s && bus.rd_ready;
   end

   assign mem_en        = wr_beat_s | rd_issue_s;
   assign mem_we        = wr_beat_s;
   assign mem_addr      = addr_r;
   assign mem_din       = (state_r == ST_WRITE) ? bus.wr_data : '0;
   assign busy          = (state_r != ST_IDLE);
   assign done          = done_r;
   assign bus.cmd_ready = (state_r == ST_IDLE);
   assign bus.wr_ready  = (state_r == ST_WRITE);
   assign bus.rd_valid  = rd_valid_s;
   assign bus.rd_data   = rd_valid_s ? fifo_mem_r[fifo_rd_ptr_r] : '0;

`ifdef LDM_BURST_RANGE_CHK_EN
   logic [AWIDTH+1:0] cmd_end_s;
   logic              err_r;

   // A burst ending beyond 2**AWIDTH is flagged at the handshake.
   always_comb begin
      cmd_end_s = {2'b00, bus.cmd_addr} + {1'b0, bus.cmd_len};
      reject_s  = cmd_end_s[AWIDTH+1] ||
                  (cmd_end_s[AWIDTH] && (cmd_end_s[AWIDTH-1:0] != '0));
   end

   // Error pulse, coincident with the done pulse of a rejected command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= (state_r == ST_IDLE) && bus.cmd_valid && reject_s;
      end
   end

   assign err = err_r;
`else
   assign reject_s = 1'b0;
   assign err      = 1'b0;
`endif

   // Command FSM with address/length counters, read-inflight flag and done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         addr_r      <= '0;
         remaining_r <= '0;
         inflight_r  <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r     <= 1'b0;
         inflight_r <= rd_issue_s;
         case (state_r)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  addr_r      <= bus.cmd_addr;
                  remaining_r <= bus.cmd_len;
                  if (reject_s || (bus.cmd_len == '0)) begin
                     done_r <= 1'b1;
                  end else if (bus.cmd_dir) begin
                     state_r <= ST_READ;
                  end else begin
                     state_r <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               if (wr_beat_s) begin
                  addr_r      <= addr_r + AWIDTH'(1);
                  remaining_r <= remaining_r - (AWIDTH+1)'(1);
                  if (last_word_s) begin
                     state_r <= ST_IDLE;
                     done_r  <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (rd_issue_s) begin
                  addr_r      <= addr_r + AWIDTH'(1);
                  remaining_r <= remaining_r - (AWIDTH+1)'(1);
                  if (last_word_s) begin
                     state_r <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Leave on the final pop itself so done lands right after the last handshake.
               if (!inflight_r && ((fifo_count_r == 2'd0) ||
                                   ((fifo_count_r == 2'd1) && fifo_pop_s))) begin
                  state_r <= ST_IDLE;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Three-entry read FIFO; a capture and a pop may happen in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_rd_ptr_r <= 2'd0;
         fifo_wr_ptr_r <= 2'd0;
         fifo_count_r  <= 2'd0;
         for (int i = 0; i < 3; i++) begin
            fifo_mem_r[i] <= '0;
         end
      end else begin
         if (fifo_push_s) begin
            fifo_mem_r[fifo_wr_ptr_r] <= mem_dout;
            fifo_wr_ptr_r             <= ptr_next(fifo_wr_ptr_r);
         end
         if (fifo_pop_s) begin
            fifo_rd_ptr_r <= ptr_next(fifo_rd_ptr_r);
         end
         case ({fifo_push_s, fifo_pop_s})
            2'b10:   fifo_count_r <= fifo_count_r + 2'd1;
            2'b01:   fifo_count_r <= fifo_count_r - 2'd1;
            default: fifo_count_r <= fifo_count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_ldm_burst_master.sv
// Self-checking bench for ldm_burst_master: randomized bursts against a reference memory image.
module tb_ldm_burst_master;
   localparam int AWIDTH = 10;
   localparam int DWIDTH = 32;
   localparam int DEPTH  = 1 << AWIDTH;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_en;
   logic              mem_we;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_din;
   logic [DWIDTH-1:0] mem_dout;
   logic              busy;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DWIDTH-1:0] ldm     [DEPTH];
   logic [DWIDTH-1:0] ref_mem [DEPTH];

   ldm_burst_master_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

   ldm_burst_master #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // LDM port model: synchronous write, one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ldm[mem_addr] <= mem_din;
         else        mem_dout      <= ldm[mem_addr];
      end
   end

   task automatic send_cmd(input logic dir, input int addr, input int len);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = dir;
      bus.cmd_addr  = AWIDTH'(addr);
      bus.cmd_len   = (AWIDTH+1)'(len);
      #1;
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_ready: got %b, expected 1", bus.cmd_ready);
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
      bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({busy, done, err, bus.cmd_ready, bus.wr_ready, bus.rd_valid, mem_en, mem_we} !== 8'b0001_0000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b, expected 00010000",
                  {busy, done, err, bus.cmd_ready, bus.wr_ready, bus.rd_valid, mem_en, mem_we});
      end
      n_checks++;
      if ({mem_addr, mem_din, bus.rd_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %h, expected zeros", mem_addr, mem_din, bus.rd_data);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, bus.cmd_ready, mem_en} !== 4'b0010) begin
         n_fail++;
         $display("FAIL reset_release: got %b, expected 0010", {busy, done, bus.cmd_ready, mem_en});
      end
   endtask

   task automatic test_write(input int addr, input int len, input bit gappy, input bit pattern);
      int beats = 0;
      int c = 0;
      logic v;
      logic [DWIDTH-1:0] d;
      send_cmd(1'b0, addr, len);
      while (beats < len && c < 400) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         c++;
         v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
         d = pattern ? (32'hA0 + DWIDTH'(beats)) : DWIDTH'($urandom);
         bus.wr_valid = v;
         bus.wr_data  = d;
         #1;
         n_checks++;
         if ({busy, bus.cmd_ready, bus.wr_ready, done, mem_en, mem_we} !== {4'b1010, v, v}) begin
            n_fail++;
            $display("FAIL write_ctl: got %b, expected %b",
                     {busy, bus.cmd_ready, bus.wr_ready, done, mem_en, mem_we}, {4'b1010, v, v});
         end
         if (v) begin
            n_checks++;
            if ({mem_addr, mem_din} !== {AWIDTH'(addr + beats), d}) begin
               n_fail++;
               $display("FAIL write_beat: got addr %h data %h, expected addr %h data %h",
                        mem_addr, mem_din, AWIDTH'(addr + beats), d);
            end
            ref_mem[(addr + beats) % DEPTH] = d;
            beats++;
         end
      end
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1;
      n_checks++;
      if (beats != len || {done, busy, bus.cmd_ready, bus.wr_ready, mem_en} !== 5'b10100) begin
         n_fail++;
         $display("FAIL write_done: got beats %0d flags %b, expected beats %0d flags 10100",
                  beats, {done, busy, bus.cmd_ready, bus.wr_ready, mem_en}, len);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL write_done_pulse: got %b, expected 0", done);
      end
   endtask

   // mode: 0 ready high, 1 ready toggling, 2 ready random, 3 ready low for 8 cycles
   task automatic test_read(input int addr, input int len, input int mode, input int abort);
      int issues = 0;
      int pops = 0;
      int c = 0;
      int ahead;
      logic rr;
      logic [DWIDTH-1:0] exp;
      send_cmd(1'b1, addr, len);
      while (pops < len && c < 400) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         c++;
         case (mode)
            0:       rr = 1'b1;
            1:       rr = c[0];
            2:       rr = 1'($urandom_range(0, 1));
            default: rr = (c > 8);
         endcase
         bus.rd_ready = rr;
         #1;
         n_checks++;
         if ({busy, bus.cmd_ready, bus.wr_ready, done, mem_we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL read_ctl: got %b, expected 10000",
                     {busy, bus.cmd_ready, bus.wr_ready, done, mem_we});
         end
         if (c == 1) begin
            n_checks++;
            if ({mem_en, mem_addr} !== {1'b1, AWIDTH'(addr)}) begin
               n_fail++;
               $display("FAIL read_first_issue: got en %b addr %h, expected en 1 addr %h",
                        mem_en, mem_addr, AWIDTH'(addr));
            end
         end
         if (mem_en) begin
            n_checks++;
            if (mem_addr !== AWIDTH'(addr + issues) || issues >= len) begin
               n_fail++;
               $display("FAIL read_issue: got addr %h (issue %0d), expected addr %h within %0d issues",
                        mem_addr, issues, AWIDTH'(addr + issues), len);
            end
            issues++;
         end
         n_checks++;
         if (issues - pops > 3) begin
            n_fail++;
            $display("FAIL read_ahead: got %0d outstanding, expected at most 3", issues - pops);
         end
         if (mode == 0) begin
            n_checks++;
            if (bus.rd_valid !== (c >= 3)) begin
               n_fail++;
               $display("FAIL read_stream: got rd_valid %b in cycle %0d, expected %b", bus.rd_valid, c, c >= 3);
            end
         end
         if (mode == 3 && c == 8) begin
            ahead = (len < 3) ? len : 3;
            n_checks++;
            if (issues != ahead) begin
               n_fail++;
               $display("FAIL read_backpressure: got %0d issued, expected %0d", issues, ahead);
            end
         end
         if (bus.rd_valid && rr) begin
            exp = ref_mem[(addr + pops) % DEPTH];
            n_checks++;
            if (bus.rd_data !== exp) begin
               n_fail++;
               $display("FAIL read_data: got %h at word %0d, expected %h", bus.rd_data, pops, exp);
            end
            pops++;
         end
         if (abort > 0 && pops == abort) begin
            rst = 1'b1;
            #1;
            n_checks++;
            if ({busy, done, err, bus.cmd_ready, bus.wr_ready, bus.rd_valid, mem_en, mem_we} !== 8'b0001_0000 ||
                {mem_addr, mem_din, bus.rd_data} !== '0) begin
               n_fail++;
               $display("FAIL reset_mid_read: got %b %h %h %h, expected 00010000 and zeros",
                        {busy, done, err, bus.cmd_ready, bus.wr_ready, bus.rd_valid, mem_en, mem_we},
                        mem_addr, mem_din, bus.rd_data);
            end
            @(negedge clk);
            rst = 1'b0;
            bus.rd_ready = 1'b0;
            #1;
            n_checks++;
            if ({done, busy, bus.rd_valid} !== 3'b000) begin
               n_fail++;
               $display("FAIL reset_no_done: got %b, expected 000", {done, busy, bus.rd_valid});
            end
            return;
         end
      end
      @(negedge clk);
      bus.rd_ready = 1'b0;
      #1;
      n_checks++;
      if (pops != len || {done, busy, bus.cmd_ready, bus.rd_valid, mem_en} !== 5'b10100) begin
         n_fail++;
         $display("FAIL read_done: got words %0d flags %b, expected words %0d flags 10100",
                  pops, {done, busy, bus.cmd_ready, bus.rd_valid, mem_en}, len);
      end
   endtask

   task automatic test_len_zero(input logic dir);
      send_cmd(dir, 16'h0055, 0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      n_checks++;
      if ({done, busy, bus.cmd_ready, mem_en, err} !== 5'b10100) begin
         n_fail++;
         $display("FAIL len_zero: got %b, expected 10100", {done, busy, bus.cmd_ready, mem_en, err});
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({done, bus.cmd_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL len_zero_pulse: got %b, expected 01", {done, bus.cmd_ready});
      end
   endtask

   task automatic test_wrap();
`ifdef LDM_BURST_RANGE_CHK_EN
      send_cmd(1'b0, 32'h3FE, 4);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.wr_valid  = 1'b1;
         bus.wr_data   = DWIDTH'($urandom);
         #1;
         n_checks++;
         if ({done, err, busy, bus.cmd_ready, bus.wr_ready, mem_en} !== ((i == 0) ? 6'b110100 : 6'b000100)) begin
            n_fail++;
            $display("FAIL range_reject: got %b in cycle %0d, expected %b",
                     {done, err, busy, bus.cmd_ready, bus.wr_ready, mem_en}, i, (i == 0) ? 6'b110100 : 6'b000100);
         end
      end
      bus.wr_valid = 1'b0;
`else
      test_write(32'h3FE, 4, 1'b0, 1'b0);
      test_read(32'h3FE, 4, 0, 0);
`endif
   endtask

   task automatic test_random_bursts();
      int len;
      int addr;
      for (int i = 0; i < 6; i++) begin
         len  = $urandom_range(1, 12);
         addr = $urandom_range(0, DEPTH - len);
         test_write(addr, len, 1'b1, 1'b0);
         test_read(addr, len, $urandom_range(0, 3), 0);
      end
   endtask

   initial begin
      test_reset();
      test_write(32'h010, 4, 1'b0, 1'b1);
      test_read(32'h010, 4, 0, 0);
      test_write(32'h100, 8, 1'b1, 1'b0);
      test_read(32'h100, 8, 1, 0);
      test_read(32'h100, 8, 2, 0);
      test_read(32'h100, 5, 3, 0);
      test_len_zero(1'b0);
      test_len_zero(1'b1);
      test_wrap();
      test_read(32'h100, 6, 0, 2);
      test_read(32'h010, 4, 0, 0);
      test_random_bursts();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ldm_burst_master.md
# ldm_burst_master

Burst access engine that drives one port of the dual-port local data memory (LDM) on behalf of the host/DMA side of the CGRA. It accepts a command (direction, start address, length) and moves a contiguous block of words. Writes stream from a valid/ready input into the LDM; reads stream from the LDM to a valid/ready output. The block handles the memory's 1-cycle read latency and output backpressure internally. The other LDM port remains free for the PE array.

## Interface
- `AWIDTH`, 10, LDM address width; must match the LDM instance.
- `DWIDTH`, 32, LDM data width.
- `clk` in 1: single clock; also drives the attached LDM port.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_dir` in 1: 0 = stream into LDM (write), 1 = LDM to stream (read).
- `cmd_addr` in AWIDTH: start word address.
- `cmd_len` in AWIDTH+1: word count, 0..2**AWIDTH.
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in DWIDTH: write stream.
- `rd_valid` out 1 / `rd_ready` in 1 / `rd_data` out DWIDTH: read stream.
- `mem_en`, `mem_we` out 1, `mem_addr` out AWIDTH, `mem_din` out DWIDTH: LDM port controls.
- `mem_dout` in DWIDTH: LDM read data, valid the cycle after an `mem_en && !mem_we` access.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: 1-cycle completion pulse.
- `err` out 1: 1-cycle range-error pulse. Only active with `LDM_BURST_RANGE_CHK_EN`.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- **IDLE**
  - `cmd_ready` = 1.
  - On handshake, latch `addr` and `remaining = cmd_len`.
  - If `cmd_len` = 0: stay in IDLE, no memory access, pulse `done` next cycle.
  - Otherwise go to WRITE or READ per `cmd_dir`.
- **WRITE**
  - `wr_ready` = 1.
  - Each beat (`wr_valid && wr_ready`): `mem_en` = `mem_we` = 1 and `mem_addr` = `addr`, combinationally that cycle; `mem_din` = `wr_data`.
  - After each beat: `addr` increments, `remaining` decrements.
  - The last beat returns the FSM to IDLE.
- **READ**
  - Read data goes into a 3-entry output FIFO.
  - Issue a read (`mem_en` = 1, `mem_we` = 0) when `remaining` > 0 and (`fifo_count` + `inflight`) < 3. `inflight` is at most 1.
  - Capture `mem_dout` into the FIFO the cycle after the issue.
  - After the last issue, go to DRAIN.
- **DRAIN**
  - Wait until the FIFO is empty and `inflight` = 0, then go to IDLE.
- `rd_valid` = FIFO non-empty; `rd_data` = FIFO head. Pop on `rd_valid && rd_ready`.
- Address arithmetic is modulo 2**AWIDTH: a burst crossing the top address wraps to 0 (without the macro).
- `cmd_ready` = 0 outside IDLE, so a new command is never accepted while busy.
- `wr_ready` = 0 outside WRITE.
- `mem_we` is never asserted in READ or DRAIN.

## Timing
- Reset values:
  - FSM = IDLE; `cmd_ready` = 1; `busy`, `done`, `err`, `rd_valid`, `wr_ready`, `mem_en`, `mem_we` = 0.
  - `mem_addr`, `mem_din`, `rd_data` = 0; FIFO empty; `inflight` = 0.
- Command accepted at edge N: first memory access at earliest in cycle N+1.
- Write:
  - 1 word/cycle while `wr_valid` stays high.
  - `done` is high in the cycle after the last write beat, together with `busy` = 0 and `cmd_ready` = 1.
- Read:
  - First issue in cycle N+1; `rd_valid` at earliest in cycle N+3.
  - Sustains 1 word/cycle while `rd_ready` stays high.
  - `done` is high in the cycle after the last `rd` handshake.
- Backpressure: with `rd_ready` low, at most 3 words are fetched ahead; issuing resumes in the cycle after a pop.
- Reset mid-burst (asserted at any time):
  - FSM, counters and FIFO clear immediately; `mem_en` drops asynchronously.
  - Partial data stays in the LDM; no `done` is produced.

## Configuration
- `LDM_BURST_RANGE_CHK_EN` defined:
  - A command with `cmd_addr` + `cmd_len` > 2**AWIDTH is rejected.
  - It is still accepted (handshake completes) but makes no memory access and consumes no stream beats.
  - `err` and `done` both pulse in the next cycle.
- Not defined:
  - No range check; such bursts wrap modulo 2**AWIDTH.
  - `err` is tied to 0.

## Test plan
- Write burst, `addr`=0x010, `len`=4, data A0..A3 with `wr_valid` held high -> `mem_we` on 4 consecutive cycles at 0x010..0x013; `done` 1 cycle after the 4th beat.
- Read back the same range with `rd_ready` held high -> `rd_data` A0..A3 on 4 consecutive cycles, first at N+3; `done` after the last beat.
- Read burst, `len`=8, `rd_ready` toggling 1/0 -> no data lost or duplicated; never more than 3 reads outstanding; order preserved.
- Write, `addr`=0x3FE, `len`=4 -> without the macro: writes at 0x3FE, 0x3FF, 0x000, 0x001. With `LDM_BURST_RANGE_CHK_EN`: no `mem_en`, `err` and `done` pulse together.
- `len`=0 command -> no `mem_en`; `done` next cycle; `cmd_ready` never drops.
- `rst` asserted mid-read (after 2 of 6 words) -> all outputs at reset values immediately; next command runs normally.
